// File: rtl/uart_pwm_pkg.sv
// Shared types and byte constants for the UART-to-servo command decoder.
package uart_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    TERM    = 2'd3
  } state_e;

  localparam logic [7:0] ACK_BYTE       = 8'h06;
  localparam logic [7:0] NAK_BYTE       = 8'h15;
  localparam logic [7:0] START_BYTE_DEF = 8'h42;
  localparam logic [7:0] TERM_BYTE_DEF  = 8'h0A;

endpackage

// File: rtl/uart_pwm_cmd_decoder_if.sv
// Byte-in / pulse-width-out / reply-byte bundle of the command decoder.
// master is the decoder side; slave is the uart_rx/uart_tx/servo side.
interface uart_pwm_cmd_decoder_if #(
  parameter int PAYLOAD_BYTES = 3
);

  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic [8*PAYLOAD_BYTES-1:0] pwm_width;
  logic                       cmd_valid;
  logic                       frame_err;
  logic [7:0]                 ack_data;
  logic                       ack_valid;
  logic                       ack_ready;
  logic                       ack_overrun;

  modport master (
    input  rx_data, rx_valid, ack_ready,
    output pwm_width, cmd_valid, frame_err, ack_data, ack_valid, ack_overrun
  );

  modport slave (
    output rx_data, rx_valid, ack_ready,
    input  pwm_width, cmd_valid, frame_err, ack_data, ack_valid, ack_overrun
  );

endinterface

// File: rtl/uart_pwm_ack_slot.sv
// One-entry reply register: a push shows up on ack_valid one cycle later and is held until
// ack_ready; a push onto an unconsumed reply overwrites it and flags ack_overrun.
module uart_pwm_ack_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ack_ready,
  output logic [7:0] ack_data,
  output logic       ack_valid,
  output logic       ack_overrun
);

  logic handshake;
  assign handshake = ack_valid && ack_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_data    <= '0;
      ack_valid   <= 1'b0;
      ack_overrun <= 1'b0;
    end else begin
      // A push coinciding with a handshake replaces a reply that is already consumed.
      ack_overrun <= push && ack_valid && !handshake;
      if (push) begin
        ack_data  <= push_data;
        ack_valid <= 1'b1;
      end else if (handshake) begin
        ack_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_pwm_cmd_decoder.sv
// Frame parser START, payload (MSB first), TERM -> clamped pwm_width; outputs 1 cycle after the last byte.
// Never back-pressures rx; UART_PWM_CMD_CHECKSUM_EN adds an XOR checksum byte before TERM.
module uart_pwm_cmd_decoder
  import uart_pwm_pkg::*;
#(
  parameter int          PAYLOAD_BYTES  = 3,
  parameter logic [7:0]  START_BYTE     = START_BYTE_DEF,
  parameter logic [7:0]  TERM_BYTE      = TERM_BYTE_DEF,
  parameter int unsigned PWM_DEFAULT    = 54054,
  parameter int unsigned PWM_MIN        = 13500,
  parameter int unsigned PWM_MAX        = 67500,
  parameter int unsigned TIMEOUT_CYCLES = 270000
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_pwm_cmd_decoder_if.master bus
);

  localparam int W     = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [W-1:0]     MIN_W    = W'(PWM_MIN);
  localparam logic [W-1:0]     MAX_W    = W'(PWM_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [W-1:0]     pwm_q, clamped;
  logic             cmd_valid_q, frame_err_q;
  logic             accept, reject;
`ifdef UART_PWM_CMD_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  always_comb begin
    if (sh_q < MIN_W)      clamped = MIN_W;
    else if (sh_q > MAX_W) clamped = MAX_W;
    else                   clamped = sh_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tmo_d   = tmo_q;
    accept  = 1'b0;
    reject  = 1'b0;
`ifdef UART_PWM_CMD_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (bus.rx_valid)          tmo_d = '0;
    else if (state_q != IDLE)  tmo_d = tmo_q + TMO_W'(1);

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.rx_valid && bus.rx_data == START_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = '0;
`ifdef UART_PWM_CMD_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      PAYLOAD: begin
        if (bus.rx_valid) begin
          sh_d  = (sh_q << 8) | W'(bus.rx_data);
          idx_d = idx_q + IDX_W'(1);
`ifdef UART_PWM_CMD_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
          if (idx_q == IDX_LAST) state_d = CHECK;
`else
          if (idx_q == IDX_LAST) state_d = TERM;
`endif
        end
      end
`ifdef UART_PWM_CMD_CHECKSUM_EN
      CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d = TERM;
          end else begin
            state_d = IDLE;
            reject  = 1'b1;
          end
        end
      end
`endif
      TERM: begin
        if (bus.rx_valid) begin
          state_d = IDLE;
          if (bus.rx_data == TERM_BYTE) accept = 1'b1;
          else                          reject = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte landing on the expiry cycle takes priority over the timeout.
    if (state_q != IDLE && !bus.rx_valid && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      tmo_d   = '0;
      reject  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sh_q        <= '0;
      tmo_q       <= '0;
      pwm_q       <= W'(PWM_DEFAULT);
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= accept;
      frame_err_q <= reject;
      if (accept) pwm_q <= clamped;
    end
  end

`ifdef UART_PWM_CMD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  assign bus.pwm_width = pwm_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.frame_err = frame_err_q;

  uart_pwm_ack_slot u_ack_slot (
    .clk         (clk),
    .reset       (reset),
    .push        (accept || reject),
    .push_data   (accept ? ACK_BYTE : NAK_BYTE),
    .ack_ready   (bus.ack_ready),
    .ack_data    (bus.ack_data),
    .ack_valid   (bus.ack_valid),
    .ack_overrun (bus.ack_overrun)
  );

endmodule
